// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: byte FIFO sitting behind a serial-to-parallel receiver.
//
// Idle/comma bytes (8'hBC) are filtered at the write side. Reads are
// registered: an accepted pop presents the oldest byte on data_out one
// cycle later, together with a single-cycle valid_out pulse.
//
// Configuration macro:
//   RX_FIFO_ERR_EN - when defined, err becomes a sticky flag. It is set by a
//                    byte dropped on a full FIFO or by a pop on an empty FIFO,
//                    and it is cleared only by reset. When undefined, err is
//                    tied to 0.
//
// Handshake semantics:
//   valid_in/data_in : the producer offers one byte per cycle while valid_in
//                      is high. There is no backpressure, so a byte that
//                      cannot be stored is lost.
//   pop              : a read request. It is accepted only when fifo_empty=0
//                      and is silently ignored otherwise.
//   valid_out        : high for exactly the one cycle after an accepted pop.
//                      data_out holds that byte and then keeps it until the
//                      next accepted pop.

module rx_byte_fifo #(
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 data_in,
    input  logic                       valid_in,
    input  logic                       pop,
    output logic [7:0]                 data_out,
    output logic                       valid_out,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0]    IDLE_BYTE = 8'hBC;
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE    = CW'(AE_THRESH);

    // Storage is never reset. After a reset the pointers are equal and
    // count is zero, so stale entries can no longer be read.
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_out_q, valid_out_d;

    logic          empty_w;
    logic          full_w;
    logic          push_req;
    logic          push_ok;
    logic          pop_ok;

    // Occupancy flags, decoded from the registered count only.
    always_comb begin
        empty_w      = (count_q == '0);
        full_w       = (count_q == CNT_FULL);
        fifo_empty   = empty_w;
        fifo_full    = full_w;
        almost_full  = (count_q >= CNT_AF);
        almost_empty = (count_q <= CNT_AE);
    end

    // Accept/reject decisions for the current cycle. A same-cycle pop
    // frees a slot on a full FIFO, but an empty FIFO never bypasses a
    // push straight to the read side.
    always_comb begin
        push_req = valid_in && (data_in != IDLE_BYTE);
        pop_ok   = pop && !empty_w;
        push_ok  = push_req && (!full_w || pop_ok);
    end

    // Next-state logic for the pointers, the count and the registered read port.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Next-state logic for the storage array: write at the write pointer on an accepted push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_in;
        end
    end

    // Storage register without reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Control register, asynchronously cleared by an active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

`ifdef RX_FIFO_ERR_EN
    logic err_q, err_d;
    logic drop_w;
    logic underflow_w;

    // Sticky error: set by a byte lost on a full FIFO or by a pop on an empty FIFO.
    always_comb begin
        drop_w      = push_req && full_w && !pop_ok;
        underflow_w = pop && empty_w;
        err_d       = err_q || drop_w || underflow_w;
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign count     = count_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb_rx_byte_fifo: directed scoreboard bench for rx_byte_fifo (DEPTH=8).
// The driver updates a queue model on each rising edge. Every accepted pop
// pushes its expected byte into exp_q. The monitor runs on the falling edge:
// it checks the flags, count, err and valid_out against the model, and it
// pops exp_q each time valid_out is high.

module tb_rx_byte_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       err;

    rx_byte_fifo #(.DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err          (err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model and scoreboard ----------------
    logic [7:0] m_q[$];      // bytes currently stored
    logic [7:0] exp_q[$];    // bytes expected on data_out, in order
    logic       exp_valid;
    logic [7:0] m_dout;
    logic       m_err;
    int         n_cmp;
    int         n_bad;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        exp_valid = 1'b0;
        m_dout    = 8'h00;
        m_err     = 1'b0;
    endtask

    // Model of one clock edge, evaluated with the pre-edge state.
    task automatic model_edge(input logic vin, input logic [7:0] din, input logic p);
        logic full, empty, pop_ok, push_req, push_ok;
        full     = (m_q.size() == 8);
        empty    = (m_q.size() == 0);
        pop_ok   = p && !empty;
        push_req = vin && (din != 8'hBC);
        push_ok  = push_req && (!full || pop_ok);
`ifdef RX_FIFO_ERR_EN
        if ((push_req && full && !pop_ok) || (p && empty)) m_err = 1'b1;
`endif
        exp_valid = pop_ok;
        if (pop_ok) begin
            m_dout = m_q.pop_front();
            exp_q.push_back(m_dout);
        end
        if (push_ok) m_q.push_back(din);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic vin, input logic [7:0] din, input logic p);
        valid_in = vin;
        data_in  = din;
        pop      = p;
        @(posedge clk);
        model_edge(vin, din, p);
        #1;
        valid_in = 1'b0;
        pop      = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},     {4'h0, count},          8'h00);
        check({tag, "_data_out"},  data_out,               8'h00);
        check({tag, "_valid_out"}, {7'h0, valid_out},      8'h00);
        check({tag, "_err"},       {7'h0, err},            8'h00);
        check({tag, "_empty"},     {7'h0, fifo_empty},     8'h01);
        check({tag, "_aempty"},    {7'h0, almost_empty},   8'h01);
        check({tag, "_full"},      {7'h0, fifo_full},      8'h00);
        check({tag, "_afull"},     {7'h0, almost_full},    8'h00);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        check("count",     {4'h0, count},        8'(m_q.size()));
        check("empty",     {7'h0, fifo_empty},   {7'h0, m_q.size() == 0});
        check("full",      {7'h0, fifo_full},    {7'h0, m_q.size() == 8});
        check("afull",     {7'h0, almost_full},  {7'h0, m_q.size() >= 6});
        check("aempty",    {7'h0, almost_empty}, {7'h0, m_q.size() <= 2});
        check("err",       {7'h0, err},          {7'h0, m_err});
        check("valid_out", {7'h0, valid_out},    {7'h0, exp_valid});
        check("data_hold", data_out,             m_dout);
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got %02h expected no output at %0t", data_out, $time);
            end else begin
                check("pop_data", data_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        valid_in = 1'b0;
        pop      = 1'b0;
        data_in  = 8'h00;
        model_reset();
        #1;
        check_reset_values("por");
        @(negedge clk);
        #1 reset = 1'b1;

        // idle/comma filtering: 10 cycles of 8'hBC
        for (int i = 0; i < 10; i++) step(1'b1, 8'hBC, 1'b0);

        // fill with 01..08, then drain in order
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        check("fill_count", {4'h0, count}, 8'h08);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // refill, overflow drop, then push+pop while full
        for (int i = 0; i < 8; i++) step(1'b1, 8'h11 + 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        check("drop_count", {4'h0, count}, 8'h08);
`ifdef RX_FIFO_ERR_EN
        check("drop_err", {7'h0, err}, 8'h01);
`else
        check("drop_err", {7'h0, err}, 8'h00);
`endif
        step(1'b1, 8'h55, 1'b1);
        check("full_pushpop_count", {4'h0, count}, 8'h08);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // pop on empty, then push+pop on empty (no bypass)
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        check("nobypass_count", {4'h0, count}, 8'h01);
        step(1'b0, 8'h00, 1'b1);

        // interleaved push/pop crossing pointer wrap
        for (int i = 0; i < 20; i++) begin
            step((i % 3) != 2, (i == 7) ? 8'hBC : 8'h60 + 8'(i), (i % 2) == 1);
        end
        while (m_q.size() != 0) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // mid-stream reset at count=5 with a pop result in flight
        for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_reset_values("mid");
        @(negedge clk);
        #1 reset = 1'b1;

        // recovery after reset
        step(1'b1, 8'h7E, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
